iterative_alu: RTL
==================

# iterative_alu

Parametrised, sequential successor to the datapath ALU. It adds registered outputs, a start/valid handshake, signed and unsigned compare, and multi-cycle unsigned multiply and divide with HI/LO result registers. It sits in the execute stage, and the pipeline stalls while `busy_o` is high. Single-cycle ops keep the existing 4-bit control encoding.

## Interface
- `WIDTH`, default 32: operand/result width, ≥ 4.
- `clk`, input, 1: clock; all state updates on rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start_i`, input, 1: request; sampled only when `busy_o` = 0.
- `alu_control`, input, 4: operation select, sampled with `start_i`.
- `op1_i`, input, WIDTH: first operand, sampled with `start_i`.
- `op2_i`, input, WIDTH: second operand, sampled with `start_i`.
- `result_o`, output, WIDTH: registered result.
- `zero_o`, output, 1: registered, equals (`result_o` == 0).
- `valid_o`, output, 1: one-cycle pulse; `result_o`/`zero_o`/`hi_o`/`lo_o` are new this cycle.
- `busy_o`, output, 1: multi-cycle op in progress; requests ignored.
- `hi_o`, output, WIDTH: HI register (product upper half / remainder).
- `lo_o`, output, WIDTH: LO register (product lower half / quotient).

## Operation
- Encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1011 SLTU, 1100 NOR, 1101 MULTU, 1110 DIVU.
- Any other code is undefined and produces result 0, single-cycle.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- SLT/SLTU produce 1 or 0, zero-extended to WIDTH.
- FSM states:
  - IDLE → IDLE on a single-cycle op.
  - IDLE → MUL on MULTU.
  - IDLE → DIV on DIVU with `op2_i` ≠ 0.
  - MUL/DIV → IDLE after WIDTH iterations.
- Iteration counter is $clog2(WIDTH+1) bits, loaded with WIDTH and decremented per iteration.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH accumulator.
  - On completion: {`hi_o`,`lo_o`} = product, `result_o` = low half.
- DIV: restoring, one quotient bit per cycle.
  - On completion: `lo_o` = quotient, `hi_o` = remainder, `result_o` = quotient.
- DIVU by zero takes no iterations and completes single-cycle with `lo_o` = all-ones, `hi_o` = `op1_i`, `result_o` = all-ones.
- Single-cycle ops leave `hi_o`/`lo_o` unchanged.
- `start_i` while `busy_o` = 1 is dropped; it is not queued.
- Operands are captured internally, so input changes during MUL/DIV have no effect.

## Timing
- Reset (`rst_n` = 0 at an edge): state IDLE, counter 0, and `result_o`, `zero_o` = 1, `valid_o`, `busy_o`, `hi_o`, `lo_o` all 0.
- Reset mid-operation aborts it; no `valid_o` follows.
- Cycle numbering: request accepted at the edge ending cycle 0.
- Single-cycle ops: `valid_o` = 1 and result visible in cycle 1; latency 1; back-to-back requests every cycle.
- MULTU/DIVU: `busy_o` = 1 in cycles 1..WIDTH; `valid_o` = 1 in cycle WIDTH+1 with `busy_o` = 0. Latency is WIDTH+1.
- A new request is accepted in cycle WIDTH+1, the same cycle as the previous `valid_o`.
- `result_o`/`zero_o` hold their last value between `valid_o` pulses.

## Configuration
- `ITERATIVE_ALU_DIV_EN` defined: DIV state, divider datapath and the DIVU encoding are built as described.
- Undefined: no divider logic. DIVU is an undefined code: latency 1, `result_o` = 0, `zero_o` = 1, `hi_o`/`lo_o` unchanged, `busy_o` never asserted by it.
- MULTU and all single-cycle ops are identical in both builds.

## Test plan
- WIDTH=32:
  - ADD 5+7 → cycle 1: `result_o`=12, `zero_o`=0, `valid_o`=1.
  - Next cycle SUB 9−9 → `result_o`=0, `zero_o`=1.
- SLT with 0xFFFFFFFF, 1 → 1. SLTU with the same operands → 0. NOR 0,0 → 0xFFFFFFFF. Code 0011 → 0.
- MULTU 0xFFFFFFFF×2 → `busy_o` high cycles 1–32; cycle 33: `valid_o`=1, `hi_o`=1, `lo_o`=`result_o`=0xFFFFFFFE. ADD request in cycle 10 produces no `valid_o` of its own.
- With `ITERATIVE_ALU_DIV_EN`:
  - DIVU 100/7 → cycle 33: `lo_o`=14, `hi_o`=2.
  - DIVU 5/0 → cycle 1: `lo_o`=0xFFFFFFFF, `hi_o`=5, `busy_o` never set.
- Without `ITERATIVE_ALU_DIV_EN`: DIVU 100/7 → cycle 1: `result_o`=0, `hi_o`/`lo_o` unchanged.
- MULTU 3×4 then `rst_n`=0 in cycle 10 → cycle 11: `busy_o`=0, `hi_o`=`lo_o`=0, and no `valid_o` through cycle 40.

Source files
------------

// File: rtl/iterative_alu.sv
// iterative_alu: registered ALU with multi-cycle shift-add MULTU; restoring DIVU
// is built only when ITERATIVE_ALU_DIV_EN is defined.
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIVU = 4'b1110;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2*WIDTH-1:0] acc, acc_d, mul_nx, step;
  logic [WIDTH-1:0] opb, opb_d, alu_res, res_d, hi_d, lo_d;
  logic [WIDTH:0] mul_sum;
  logic valid_d;
  // acc = {partial product, remaining multiplier bits}; one bit retired per cycle
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb & {WIDTH{acc[0]}}};
  assign mul_nx = {mul_sum, acc[WIDTH-1:1]};
`ifdef ITERATIVE_ALU_DIV_EN
  logic [WIDTH:0] rem_sh;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH-1:0] div_nx;
  // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
  assign rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = {1'b0, rem_sh} - {2'b0, opb};
  assign div_nx = {diff[WIDTH+1] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH+1]};
  assign step = state == DIV ? div_nx : mul_nx;
`else
  assign step = mul_nx;
`endif
  assign busy_o = state != IDLE;
  always_comb begin
    case (alu_control)
      4'b0000: alu_res = op1_i & op2_i;
      4'b0001: alu_res = op1_i | op2_i;
      4'b0010: alu_res = op1_i + op2_i;
      4'b0110: alu_res = op1_i - op2_i;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
      4'b1011: alu_res = {{(WIDTH-1){1'b0}}, op1_i < op2_i};
      4'b1100: alu_res = ~(op1_i | op2_i);
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    acc_d = acc;
    opb_d = opb;
    res_d = result_o;
    hi_d = hi_o;
    lo_d = lo_o;
    valid_d = 1'b0;
    case (state)
      IDLE: if (start_i) begin
        if (alu_control == OP_MULTU) begin
          state_d = MUL;
          cnt_d = CW'(WIDTH);
          acc_d = {{WIDTH{1'b0}}, op1_i};
          opb_d = op2_i;
        end
`ifdef ITERATIVE_ALU_DIV_EN
        else if (alu_control == OP_DIVU && op2_i != '0) begin
          state_d = DIV;
          cnt_d = CW'(WIDTH);
          acc_d = {{WIDTH{1'b0}}, op1_i};
          opb_d = op2_i;
        end else if (alu_control == OP_DIVU) begin
          valid_d = 1'b1;
          res_d = '1;
          hi_d = op1_i;
          lo_d = '1;
        end
`endif
        else begin
          valid_d = 1'b1;
          res_d = alu_res;
        end
      end
      MUL, DIV: begin
        acc_d = step;
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_d = IDLE;
          valid_d = 1'b1;
          hi_d = step[2*WIDTH-1:WIDTH];
          lo_d = step[WIDTH-1:0];
          res_d = step[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      opb <= '0;
      result_o <= '0;
      zero_o <= 1'b1;
      valid_o <= 1'b0;
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      acc <= acc_d;
      opb <= opb_d;
      result_o <= res_d;
      zero_o <= res_d == '0;
      valid_o <= valid_d;
      hi_o <= hi_d;
      lo_o <= lo_d;
    end
  end
endmodule
